epp_host: RTL

Byte-wide EPP host (initiator) that drives the Astb/Dstb/Wr/DB/Wait handshake from the host side. It is the counterpart of the board's EPP peripheral register port. A local command interface requests one address write followed by 1–4 data bytes, written or read, LSB first. The block lets one board set another board's sync-time register (or read its current time) over the EPP pins, and serves as the bus-functional host in peripheral benches.

---
 rtl/epp_host.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/epp_host.sv
// epp_host: byte-wide EPP host; one address cycle then 1-4 data bytes, LSB first.
// Define EPP_HOST_TIMEOUT_EN to abort a transaction when Wait stalls too long.
module epp_host #(
  parameter int SETUP_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_len,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_timeout,
  output logic [31:0] rsp_rdata,
  output logic        EppAstb,
  output logic        EppDstb,
  output logic        EppWr,
  inout  wire  [7:0]  EppDB,
  input  logic        EppWait
);

  // state   | meaning
  // IDLE    | ready for a command, strobes high, bus released
  // SETUP   | Wr/DB driven, counting SETUP_CYCLES cycles with Wait low
  // STROBE  | selected strobe low until synced Wait rises
  // RELEASE | strobe high until synced Wait falls
  // HOLD    | Wr/DB held for HOLD_CYCLES cycles
  // DONE    | one-cycle rsp_valid, then bus returns to idle
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RELEASE = 3'd3,
    HOLD    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int PH_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int PHW = $clog2(PH_MAX + 1);
  localparam logic [PHW-1:0] SETUP_LOAD = PHW'(SETUP_CYCLES - 1);
  localparam logic [PHW-1:0] HOLD_LOAD  = PHW'(HOLD_CYCLES - 1);

  state_t         state;
  logic           wait_m;
  logic           wait_s;
  logic [PHW-1:0] ph_cnt;
  logic           is_addr;
  logic [1:0]     didx;
  logic           write_r;
  logic [1:0]     len_r;
  logic [31:0]    wdata_r;
  logic           db_oe;
  logic [7:0]     db_out;
  logic           accept;
  logic           to_hit;
  logic           last_byte;
  logic [1:0]     next_didx;

  assign accept    = cmd_valid && cmd_ready;
  assign last_byte = !is_addr && (didx == len_r);
  assign next_didx = is_addr ? 2'd0 : didx + 2'd1;
  assign EppDB     = db_oe ? db_out : 8'hzz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_m <= 1'b0;
      wait_s <= 1'b0;
    end else begin
      wait_m <= EppWait;
      wait_s <= wait_m;
    end
  end

`ifdef EPP_HOST_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TOW-1:0] to_cnt;
  logic           to_count;
  logic           to_flag;

  // Only cycles spent waiting on the peripheral are charged to the byte.
  assign to_count = ((state == SETUP)   &&  wait_s) ||
                    ((state == STROBE)  && !wait_s) ||
                    ((state == RELEASE) &&  wait_s);
  assign to_hit   = to_count && (to_cnt == TOW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt  <= TOW'(TIMEOUT_CYCLES);
      to_flag <= 1'b0;
    end else begin
      if ((state == SETUP) || (state == STROBE) || (state == RELEASE)) begin
        if (to_count) to_cnt <= to_cnt - TOW'(1);
      end else begin
        to_cnt <= TOW'(TIMEOUT_CYCLES);
      end
      if (accept)      to_flag <= 1'b0;
      else if (to_hit) to_flag <= 1'b1;
    end
  end

  assign rsp_timeout = to_flag;
`else
  assign to_hit      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      EppAstb   <= 1'b1;
      EppDstb   <= 1'b1;
      EppWr     <= 1'b1;
      db_oe     <= 1'b0;
      db_out    <= '0;
      ph_cnt    <= '0;
      is_addr   <= 1'b0;
      didx      <= '0;
      write_r   <= 1'b0;
      len_r     <= '0;
      wdata_r   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (to_hit) begin
        state     <= DONE;
        EppAstb   <= 1'b1;
        EppDstb   <= 1'b1;
        EppWr     <= 1'b1;
        db_oe     <= 1'b0;
        rsp_valid <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              write_r   <= cmd_write;
              len_r     <= cmd_len;
              wdata_r   <= cmd_wdata;
              rsp_rdata <= '0;
              cmd_ready <= 1'b0;
              is_addr   <= 1'b1;
              didx      <= '0;
              ph_cnt    <= SETUP_LOAD;
              EppWr     <= 1'b0;
              db_oe     <= 1'b1;
              db_out    <= cmd_addr;
              state     <= SETUP;
            end
          end
          SETUP: begin
            if (!wait_s) begin
              if (ph_cnt == '0) begin
                state <= STROBE;
                if (is_addr) EppAstb <= 1'b0;
                else         EppDstb <= 1'b0;
              end else begin
                ph_cnt <= ph_cnt - PHW'(1);
              end
            end
          end
          STROBE: begin
            if (wait_s) begin
              state   <= RELEASE;
              EppAstb <= 1'b1;
              EppDstb <= 1'b1;
              if (!is_addr && !write_r) rsp_rdata[{didx, 3'b000} +: 8] <= EppDB;
            end
          end
          RELEASE: begin
            if (!wait_s) begin
              state  <= HOLD;
              ph_cnt <= HOLD_LOAD;
            end
          end
          HOLD: begin
            if (ph_cnt != '0) begin
              ph_cnt <= ph_cnt - PHW'(1);
            end else if (last_byte) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end else begin
              // Wr and DB change together so DB is never driven while Wr=1.
              is_addr <= 1'b0;
              didx    <= next_didx;
              ph_cnt  <= SETUP_LOAD;
              EppWr   <= ~write_r;
              db_oe   <= write_r;
              db_out  <= wdata_r[{next_didx, 3'b000} +: 8];
              state   <= SETUP;
            end
          end
          DONE: begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            EppWr     <= 1'b1;
            db_oe     <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
